// File: rtl/cascade_counter_if.sv
// Control and status bundle for cascade_counter.
// master drives the controls and observes the counter; slave is the counter.
interface cascade_counter_if #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
);
  logic                      cen;
  logic                      clr;
  logic                      load;
  logic [STAGES*WIDTH-1:0]   load_val;
  logic [STAGES*WIDTH-1:0]   max_val;
  logic                      dir;
  logic [1:0]                mode;
  logic [STAGES*WIDTH-1:0]   count;
  logic [STAGES-1:0]         tc;
  logic                      done;
  logic                      sat;

  modport master (
    output cen, clr, load, load_val, max_val, dir, mode,
    input  count, tc, done, sat
  );

  modport slave (
    input  cen, clr, load, load_val, max_val, dir, mode,
    output count, tc, done, sat
  );
endinterface

// File: rtl/cascade_counter.sv
// Multi-stage chained counter with runtime terminal values, up/down
// direction, synchronous clear/load and wrap/saturate/one-shot modes.
// Stage 0 is least significant; stage k steps only when every lower
// stage is terminal on the same edge (single-cycle ripple).
module cascade_counter #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input logic             clk,
  input logic             rst,
  cascade_counter_if.slave bus
);

  localparam logic [1:0] MODE_SAT  = 2'b01;
  localparam logic [1:0] MODE_SHOT = 2'b10;

  logic [STAGES-1:0][WIDTH-1:0] cnt_q, cnt_d;
  logic [STAGES-1:0]            tc_q, tc_d;
  logic                         done_q, done_d;
  logic                         sat_q, sat_d;

  logic [STAGES-1:0]            term;
  logic [STAGES-1:0]            adv;
  logic                         cen_eff;
  logic                         chain_term;
  logic                         hold_sat;
  logic                         hold_shot;

  // A finished one-shot ignores cen until it is cleared or reloaded.
  assign cen_eff    = bus.cen & ~done_q;
  assign chain_term = &term;
  assign hold_sat   = cen_eff & chain_term & (bus.mode == MODE_SAT);
  assign hold_shot  = cen_eff & chain_term & (bus.mode == MODE_SHOT);

  // Per-stage terminal detect and the advance ripple from stage 0 upward.
  always_comb begin
    logic ripple;
    term   = '0;
    adv    = '0;
    ripple = cen_eff;
    for (int k = 0; k < STAGES; k++) begin
      if (bus.dir)
        term[k] = (cnt_q[k] == '0);
      else
        term[k] = (cnt_q[k] >= bus.max_val[k*WIDTH +: WIDTH]);
      adv[k] = ripple;
      ripple = ripple & term[k];
    end
  end

  // Next count, rollover pulses and hold flags; clr beats load beats cen.
  always_comb begin
    cnt_d  = cnt_q;
    tc_d   = '0;
    done_d = done_q;
    sat_d  = sat_q;
    if (bus.clr) begin
      cnt_d  = '0;
      done_d = 1'b0;
      sat_d  = 1'b0;
    end else if (bus.load) begin
      cnt_d  = bus.load_val;
      done_d = 1'b0;
      sat_d  = 1'b0;
    end else if (hold_sat) begin
      sat_d = 1'b1;
    end else if (hold_shot) begin
      done_d = 1'b1;
    end else begin
      // Saturation is released once counting can make progress again.
      if (cen_eff && !chain_term)
        sat_d = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          if (term[k]) begin
            cnt_d[k] = bus.dir ? bus.max_val[k*WIDTH +: WIDTH] : '0;
            tc_d[k]  = 1'b1;
          end else if (bus.dir) begin
            cnt_d[k] = cnt_q[k] - WIDTH'(1);
          end else begin
            cnt_d[k] = cnt_q[k] + WIDTH'(1);
          end
        end
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      tc_q   <= '0;
      done_q <= 1'b0;
      sat_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tc_q   <= tc_d;
      done_q <= done_d;
      sat_q  <= sat_d;
    end
  end

  assign bus.count = cnt_q;
  assign bus.tc    = tc_q;
  assign bus.done  = done_q;
  assign bus.sat   = sat_q;

endmodule

// File: tb/tb_cascade_counter.sv
// Self-checking bench for cascade_counter: directed vector table,
// a hand-written async reset sequence, then random stimulus against
// a behavioural model.
module tb_cascade_counter;
  localparam int W = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cascade_counter_if #(.WIDTH(W), .STAGES(S)) bus ();
  cascade_counter #(.WIDTH(W), .STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] pk(input int s1, input int s0);
    logic [7:0] r;
    r[3:0] = s0[3:0];
    r[7:4] = s1[3:0];
    return r;
  endfunction

  typedef struct {
    logic       cen, clr, load, dir;
    logic [1:0] mode;
    logic [7:0] lv, mx, ec;
    logic [1:0] etc;
    logic       ed, es;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic cen, clr, load, dir, input logic [1:0] mode,
                              input logic [7:0] lv, mx, ec, input logic [1:0] etc,
                              input logic ed, es);
    vec_t v;
    v.cen = cen; v.clr = clr; v.load = load; v.dir = dir; v.mode = mode;
    v.lv = lv; v.mx = mx; v.ec = ec; v.etc = etc; v.ed = ed; v.es = es;
    tbl.push_back(v);
  endfunction

  // Behavioural reference: stage values as integers, counting rules applied directly.
  int         mc[S];
  logic [S-1:0] mtc;
  logic       mdone, msat;

  function automatic bit at_end(input int v, input int m, input logic d);
    return d ? (v == 0) : (v >= m);
  endfunction

  task automatic model_step();
    int  mx[S];
    int  lv[S];
    bit  allterm;
    bit  carry;
    for (int k = 0; k < S; k++) begin
      mx[k] = int'(bus.max_val[k*W +: W]);
      lv[k] = int'(bus.load_val[k*W +: W]);
    end
    mtc = '0;
    if (bus.clr) begin
      for (int k = 0; k < S; k++) mc[k] = 0;
      mdone = 0; msat = 0;
    end else if (bus.load) begin
      for (int k = 0; k < S; k++) mc[k] = lv[k];
      mdone = 0; msat = 0;
    end else if (bus.cen && !mdone) begin
      allterm = 1;
      for (int k = 0; k < S; k++)
        if (!at_end(mc[k], mx[k], bus.dir)) allterm = 0;
      if (allterm && bus.mode == 2'b01) msat = 1;
      else if (allterm && bus.mode == 2'b10) mdone = 1;
      else begin
        if (!allterm) msat = 0;
        carry = 1;
        for (int k = 0; k < S && carry; k++) begin
          if (at_end(mc[k], mx[k], bus.dir)) begin
            mc[k] = bus.dir ? mx[k] : 0;
            mtc[k] = 1;
          end else begin
            mc[k] = bus.dir ? mc[k] - 1 : mc[k] + 1;
            carry = 0;
          end
        end
      end
    end
  endtask

  function automatic logic [7:0] model_count();
    logic [7:0] r;
    int v;
    r = '0;
    for (int k = 0; k < S; k++) begin
      v = mc[k];
      r[k*W +: W] = v[W-1:0];
    end
    return r;
  endfunction

  initial begin
    int n;
    rst = 1'b1;
    bus.cen = 0; bus.clr = 0; bus.load = 0; bus.dir = 0; bus.mode = 2'b00;
    bus.load_val = '0; bus.max_val = '0;

    // Wrap up, max s1=2 s0=3: 12-step cycle plus one extra step.
    for (int i = 1; i <= 13; i++) begin
      n = i % 12;
      add(1, 0, 0, 0, 2'b00, 8'h00, pk(2, 3), pk(n / 4, n % 4),
          {(n == 0) ? 1'b1 : 1'b0, (n % 4 == 0) ? 1'b1 : 1'b0}, 0, 0);
    end
    // Down from zero: both stages roll to their max.
    add(0, 0, 1, 0, 2'b00, 8'h00, pk(2, 3), pk(0, 0), 2'b00, 0, 0);
    add(1, 0, 0, 1, 2'b00, 8'h00, pk(2, 3), pk(2, 3), 2'b11, 0, 0);
    add(0, 0, 0, 1, 2'b00, 8'h00, pk(2, 3), pk(2, 3), 2'b00, 0, 0);
    // Saturate up, max {1,1}, then release by flipping direction.
    add(0, 1, 0, 0, 2'b01, 8'h00, pk(1, 1), pk(0, 0), 2'b00, 0, 0);
    add(1, 0, 0, 0, 2'b01, 8'h00, pk(1, 1), pk(0, 1), 2'b00, 0, 0);
    add(1, 0, 0, 0, 2'b01, 8'h00, pk(1, 1), pk(1, 0), 2'b01, 0, 0);
    add(1, 0, 0, 0, 2'b01, 8'h00, pk(1, 1), pk(1, 1), 2'b00, 0, 0);
    add(1, 0, 0, 0, 2'b01, 8'h00, pk(1, 1), pk(1, 1), 2'b00, 0, 1);
    add(1, 0, 0, 0, 2'b01, 8'h00, pk(1, 1), pk(1, 1), 2'b00, 0, 1);
    add(1, 0, 0, 0, 2'b01, 8'h00, pk(1, 1), pk(1, 1), 2'b00, 0, 1);
    add(1, 0, 0, 1, 2'b01, 8'h00, pk(1, 1), pk(1, 0), 2'b00, 0, 0);
    // One-shot, max s1=0 s0=2.
    add(0, 1, 0, 0, 2'b10, 8'h00, pk(0, 2), pk(0, 0), 2'b00, 0, 0);
    add(1, 0, 0, 0, 2'b10, 8'h00, pk(0, 2), pk(0, 1), 2'b00, 0, 0);
    add(1, 0, 0, 0, 2'b10, 8'h00, pk(0, 2), pk(0, 2), 2'b00, 0, 0);
    add(1, 0, 0, 0, 2'b10, 8'h00, pk(0, 2), pk(0, 2), 2'b00, 1, 0);
    add(1, 0, 0, 1, 2'b10, 8'h00, pk(0, 2), pk(0, 2), 2'b00, 1, 0);
    add(0, 1, 0, 1, 2'b10, 8'h00, pk(0, 2), pk(0, 0), 2'b00, 0, 0);
    // Lowering max below the current count forces an immediate rollover.
    add(0, 0, 1, 0, 2'b00, pk(0, 7), pk(2, 9), pk(0, 7), 2'b00, 0, 0);
    add(1, 0, 0, 0, 2'b00, pk(0, 7), pk(2, 5), pk(1, 0), 2'b01, 0, 0);
    // Priority: clr over load over cen.
    add(1, 1, 1, 0, 2'b00, pk(1, 2), pk(2, 5), pk(0, 0), 2'b00, 0, 0);
    add(1, 0, 1, 0, 2'b00, pk(1, 2), pk(2, 5), pk(1, 2), 2'b00, 0, 0);

    #3;
    chk("reset count", bus.count, 8'h00);
    chk("reset tc", bus.tc, 2'b00);
    chk("reset done", bus.done, 1'b0);
    chk("reset sat", bus.sat, 1'b0);
    #9 rst = 1'b0;

    foreach (tbl[i]) begin
      bus.cen = tbl[i].cen; bus.clr = tbl[i].clr; bus.load = tbl[i].load;
      bus.dir = tbl[i].dir; bus.mode = tbl[i].mode;
      bus.load_val = tbl[i].lv; bus.max_val = tbl[i].mx;
      @(posedge clk); #1;
      chk($sformatf("vec%0d count", i), bus.count, tbl[i].ec);
      chk($sformatf("vec%0d tc", i), bus.tc, tbl[i].etc);
      chk($sformatf("vec%0d done", i), bus.done, tbl[i].ed);
      chk($sformatf("vec%0d sat", i), bus.sat, tbl[i].es);
    end

    // Async reset in the middle of counting.
    bus.cen = 1; bus.clr = 0; bus.load = 0; bus.dir = 0; bus.mode = 2'b00;
    bus.max_val = pk(2, 3);
    @(posedge clk); #1;
    chk("pre-rst count", bus.count, pk(1, 3));
    @(posedge clk); #1;
    chk("pre-rst count2", bus.count, pk(2, 0));
    chk("pre-rst tc", bus.tc, 2'b01);
    #2 rst = 1'b1;
    #1;
    chk("async rst count", bus.count, 8'h00);
    chk("async rst tc", bus.tc, 2'b00);
    #3 rst = 1'b0;
    @(posedge clk); #1;
    chk("post-rst count", bus.count, pk(0, 1));

    // Random stimulus against the model.
    rst = 1'b1;
    bus.cen = 0;
    #2 rst = 1'b0;
    for (int k = 0; k < S; k++) mc[k] = 0;
    mtc = '0; mdone = 0; msat = 0;
    for (int c = 0; c < 600; c++) begin
      bus.cen  = ($urandom_range(0, 99) < 80);
      bus.clr  = ($urandom_range(0, 99) < 2);
      bus.load = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 99) < 10) bus.dir = ~bus.dir;
      if ($urandom_range(0, 99) < 5) bus.mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 10)
        for (int k = 0; k < S; k++) bus.max_val[k*W +: W] = W'($urandom_range(0, 6));
      for (int k = 0; k < S; k++) bus.load_val[k*W +: W] = W'($urandom_range(0, 15));
      model_step();
      @(posedge clk); #1;
      chk($sformatf("rnd%0d count", c), bus.count, model_count());
      chk($sformatf("rnd%0d tc", c), bus.tc, mtc);
      chk($sformatf("rnd%0d done", c), bus.done, mdone);
      chk($sformatf("rnd%0d sat", c), bus.sat, msat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
